// File: rtl/mcs6530_pkg.sv
// Shared types and constants for the mcs6530 bus initiator: FSM states and the
// idle-bus pattern, which deselects every space in the responder.
package mcs6530_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    localparam logic [9:0] IDLE_A           = 10'h000;
    localparam logic [7:0] IDLE_DI          = 8'h00;
    localparam logic       IDLE_WE_N        = 1'b1;
    localparam logic       IDLE_RS0         = 1'b0;
    localparam logic       IDLE_CS1         = 1'b0;
    localparam logic [7:0] OPEN_BUS_DEFAULT = 8'hFF;

endpackage

// File: rtl/irq_sync.sv
// Two-flop synchroniser for the responder IRQ, with a registered rising-edge
// pulse that coincides with the first high cycle of the level.
module irq_sync (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta  <= 1'b0;
            level <= 1'b0;
            rise  <= 1'b0;
        end else begin
            meta  <= din;
            level <= meta;
            rise  <= meta & ~level;
        end
    end

endmodule

// File: rtl/mcs6530_bus_master.sv
// Single-beat bus initiator for the mcs6530 RRIOT: turns request/response
// handshakes into 6502-style bus cycles and flags reads that never see OE.
module mcs6530_bus_master
    import mcs6530_pkg::*;
#(
    parameter int         WAIT_MAX = 4,
    parameter logic [7:0] OPEN_BUS = OPEN_BUS_DEFAULT
) (
    input  logic       phi2,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_we,
    input  logic       req_rom,
    input  logic [9:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic       rsp_err,
    output logic [9:0] bus_a,
    output logic [7:0] bus_di,
    output logic       bus_we_n,
    output logic       bus_rs0,
    output logic       bus_cs1,
    input  logic [7:0] bus_do,
    input  logic       bus_oe,
    input  logic       bus_irq,
    output logic       irq_level,
    output logic       irq_rise
);

    localparam int              CW       = $clog2(WAIT_MAX + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(WAIT_MAX - 1);
    localparam logic [CW-1:0]   CNT_MAX  = CW'(WAIT_MAX);

    state_t        state;
    logic [CW-1:0] wait_cnt;

    // The registered bus outputs double as the latched request: bus_we_n
    // still holds ~we while in BUS, so no separate copy is kept.
    always_ff @(posedge phi2 or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            wait_cnt  <= '0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= 8'h00;
            rsp_err   <= 1'b0;
            bus_a     <= IDLE_A;
            bus_di    <= IDLE_DI;
            bus_we_n  <= IDLE_WE_N;
            bus_rs0   <= IDLE_RS0;
            bus_cs1   <= IDLE_CS1;
        end else begin
            case (state)
                S_IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        bus_a     <= req_addr;
                        bus_di    <= req_we ? req_wdata : 8'h00;
                        bus_we_n  <= ~req_we;
                        bus_rs0   <= ~req_rom;
                        bus_cs1   <= req_rom;
                        req_ready <= 1'b0;
                        state     <= S_BUS;
                    end
                end
                S_BUS: begin
                    if (!bus_we_n) begin
                        rsp_data  <= 8'h00;
                        rsp_err   <= 1'b0;
                        rsp_valid <= 1'b1;
                        bus_a     <= IDLE_A;
                        bus_di    <= IDLE_DI;
                        bus_we_n  <= IDLE_WE_N;
                        bus_rs0   <= IDLE_RS0;
                        bus_cs1   <= IDLE_CS1;
                        state     <= S_RESP;
                    end else begin
                        wait_cnt <= '0;
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus_oe || wait_cnt >= CNT_LAST) begin
                        rsp_data  <= bus_oe ? bus_do : OPEN_BUS;
                        rsp_err   <= ~bus_oe;
                        rsp_valid <= 1'b1;
                        bus_a     <= IDLE_A;
                        bus_di    <= IDLE_DI;
                        bus_we_n  <= IDLE_WE_N;
                        bus_rs0   <= IDLE_RS0;
                        bus_cs1   <= IDLE_CS1;
                        state     <= S_RESP;
                    end else if (wait_cnt != CNT_MAX) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    irq_sync u_irq_sync (
        .clk   (phi2),
        .rst   (rst),
        .din   (bus_irq),
        .level (irq_level),
        .rise  (irq_rise)
    );

endmodule

// File: tb/tb_mcs6530_bus_master.sv
// Directed bench for mcs6530_bus_master with a small behavioural RRIOT
// responder: 64-byte RAM, ROM byte = addr[7:0]^5A, OE gated by oe_en.
module tb_mcs6530_bus_master;

    logic       phi2, rst;
    logic       req_valid, req_ready, req_we, req_rom;
    logic [9:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid, rsp_ready, rsp_err;
    logic [7:0] rsp_data;
    logic [9:0] bus_a;
    logic [7:0] bus_di, bus_do;
    logic       bus_we_n, bus_rs0, bus_cs1, bus_oe, bus_irq;
    logic       irq_level, irq_rise;

    int checks = 0;
    int failures = 0;

    logic       oe_en;
    logic       ram_clr;
    logic [7:0] ram [64];
    logic       sel_ram, sel_rom;

    mcs6530_bus_master #(.WAIT_MAX(4), .OPEN_BUS(8'hFF)) dut (
        .phi2(phi2), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_rom(req_rom), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .bus_a(bus_a), .bus_di(bus_di), .bus_we_n(bus_we_n),
        .bus_rs0(bus_rs0), .bus_cs1(bus_cs1), .bus_do(bus_do), .bus_oe(bus_oe),
        .bus_irq(bus_irq), .irq_level(irq_level), .irq_rise(irq_rise)
    );

    initial phi2 = 1'b0;
    always #5 phi2 = ~phi2;

    always_comb begin
        sel_ram = bus_rs0 && !bus_cs1;
        sel_rom = bus_cs1 && !bus_rs0;
        bus_oe  = oe_en && bus_we_n && (sel_ram || sel_rom);
        bus_do  = sel_rom ? (bus_a[7:0] ^ 8'h5A) : ram[bus_a[5:0]];
    end

    always @(posedge phi2) begin
        if (ram_clr) begin
            for (int i = 0; i < 64; i++) ram[i] <= 8'h00;
        end else if (sel_ram && !bus_we_n) begin
            ram[bus_a[5:0]] <= bus_di;
        end
    end

    // Offer one request, then count edges from the accept edge until rsp_valid.
    task automatic issue(input logic we, input logic rom, input logic [9:0] addr,
                         input logic [7:0] wd, output int lat, output int we_low,
                         output logic sel_bad);
        int guard = 0;
        while (!req_ready && guard < 20) begin
            @(posedge phi2); #1; guard++;
        end
        req_valid = 1'b1; req_we = we; req_rom = rom; req_addr = addr; req_wdata = wd;
        @(posedge phi2); #1;
        req_valid = 1'b0;
        lat = 0; we_low = 0; sel_bad = 1'b0;
        while (!rsp_valid && lat < 20) begin
            if (!bus_we_n) we_low++;
            if (bus_rs0 !== ~rom || bus_cs1 !== rom || bus_a !== addr) sel_bad = 1'b1;
            @(posedge phi2); #1; lat++;
        end
        if (!rsp_valid) lat = -1;
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        @(posedge phi2); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; ram_clr = 1'b1;
        repeat (3) @(posedge phi2);
        #1;
        checks++;
        if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_data !== 8'h00 || rsp_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_rsp: req_ready=%b rsp_valid=%b rsp_data=%h rsp_err=%b, expected 0 0 00 0",
                     req_ready, rsp_valid, rsp_data, rsp_err);
        end
        checks++;
        if (bus_we_n !== 1'b1 || bus_rs0 !== 1'b0 || bus_cs1 !== 1'b0 || bus_a !== 10'h0 ||
            bus_di !== 8'h00 || irq_level !== 1'b0 || irq_rise !== 1'b0) begin
            failures++;
            $display("FAIL reset_bus: we_n=%b rs0=%b cs1=%b a=%h di=%h irq=%b/%b, expected idle bus",
                     bus_we_n, bus_rs0, bus_cs1, bus_a, bus_di, irq_level, irq_rise);
        end
        ram_clr = 1'b0;
        rst = 1'b0;
        checks++;
        if (req_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_release_now: req_ready=%b expected 0", req_ready);
        end
        @(posedge phi2); #1;
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_next: req_ready=%b expected 1", req_ready);
        end
    endtask

    task automatic test_write_read();
        int lat, we_low;
        logic sel_bad;
        issue(1'b1, 1'b0, 10'h380, 8'hA5, lat, we_low, sel_bad);
        checks++;
        if (lat != 1 || we_low != 1 || sel_bad) begin
            failures++;
            $display("FAIL write_timing: lat=%0d we_low=%0d sel_bad=%b, expected 1 1 0", lat, we_low, sel_bad);
        end
        checks++;
        if (rsp_data !== 8'h00 || rsp_err !== 1'b0 || bus_we_n !== 1'b1) begin
            failures++;
            $display("FAIL write_rsp: data=%h err=%b we_n=%b, expected 00 0 1", rsp_data, rsp_err, bus_we_n);
        end
        handshake();
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            failures++;
            $display("FAIL write_handshake: rsp_valid=%b req_ready=%b, expected 0 1", rsp_valid, req_ready);
        end
        issue(1'b0, 1'b0, 10'h380, 8'h00, lat, we_low, sel_bad);
        checks++;
        if (lat != 2 || we_low != 0 || sel_bad || rsp_data !== 8'hA5 || rsp_err !== 1'b0) begin
            failures++;
            $display("FAIL ram_read: lat=%0d we_low=%0d sel_bad=%b data=%h err=%b, expected 2 0 0 A5 0",
                     lat, we_low, sel_bad, rsp_data, rsp_err);
        end
        handshake();
    endtask

    task automatic test_rom_read();
        int lat, we_low;
        logic sel_bad;
        issue(1'b0, 1'b1, 10'h000, 8'h00, lat, we_low, sel_bad);
        checks++;
        if (lat != 2 || sel_bad || rsp_data !== 8'h5A || rsp_err !== 1'b0) begin
            failures++;
            $display("FAIL rom_read: lat=%0d sel_bad=%b data=%h err=%b, expected 2 0 5A 0",
                     lat, sel_bad, rsp_data, rsp_err);
        end
        handshake();
    endtask

    task automatic test_open_bus();
        int lat, we_low;
        logic sel_bad;
        oe_en = 1'b0;
        issue(1'b0, 1'b0, 10'h380, 8'h00, lat, we_low, sel_bad);
        checks++;
        if (lat != 5 || rsp_data !== 8'hFF || rsp_err !== 1'b1) begin
            failures++;
            $display("FAIL open_bus: lat=%0d data=%h err=%b, expected 5 FF 1", lat, rsp_data, rsp_err);
        end
        req_valid = 1'b1; req_we = 1'b1; req_addr = 10'h381; req_wdata = 8'h99;
        for (int c = 0; c < 5; c++) begin
            @(posedge phi2); #1;
            checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== 8'hFF || rsp_err !== 1'b1 || req_ready !== 1'b0 ||
                bus_we_n !== 1'b1 || bus_rs0 !== 1'b0 || bus_cs1 !== 1'b0 || bus_a !== 10'h0) begin
                failures++;
                $display("FAIL hold_cycle%0d: valid=%b data=%h err=%b ready=%b we_n=%b rs0=%b cs1=%b a=%h, expected 1 FF 1 0 1 0 0 000",
                         c, rsp_valid, rsp_data, rsp_err, req_ready, bus_we_n, bus_rs0, bus_cs1, bus_a);
            end
        end
        req_valid = 1'b0;
        handshake();
        oe_en = 1'b1;
    endtask

    task automatic test_back_to_back();
        int lat, we_low;
        logic sel_bad;
        issue(1'b1, 1'b0, 10'h385, 8'h3C, lat, we_low, sel_bad);
        handshake();
        checks++;
        if (req_ready !== 1'b1 || bus_we_n !== 1'b1) begin
            failures++;
            $display("FAIL b2b_ready: req_ready=%b we_n=%b, expected 1 1", req_ready, bus_we_n);
        end
        issue(1'b0, 1'b0, 10'h385, 8'h00, lat, we_low, sel_bad);
        checks++;
        if (lat != 2 || rsp_data !== 8'h3C || rsp_err !== 1'b0) begin
            failures++;
            $display("FAIL b2b_read: lat=%0d data=%h err=%b, expected 2 3C 0", lat, rsp_data, rsp_err);
        end
        handshake();
    endtask

    task automatic test_reset_mid_write();
        int lat, we_low;
        logic sel_bad;
        issue(1'b1, 1'b0, 10'h3C1, 8'h11, lat, we_low, sel_bad);
        handshake();
        req_valid = 1'b1; req_we = 1'b1; req_rom = 1'b0; req_addr = 10'h3C1; req_wdata = 8'h77;
        @(posedge phi2); #1;
        req_valid = 1'b0;
        checks++;
        if (bus_we_n !== 1'b0) begin
            failures++;
            $display("FAIL midwr_bus: we_n=%b expected 0", bus_we_n);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus_we_n !== 1'b1 || bus_rs0 !== 1'b0 || req_ready !== 1'b0) begin
            failures++;
            $display("FAIL midwr_async: we_n=%b rs0=%b ready=%b, expected 1 0 0", bus_we_n, bus_rs0, req_ready);
        end
        @(posedge phi2); #1;
        rst = 1'b0;
        @(posedge phi2); #1;
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL midwr_release: ready=%b valid=%b, expected 1 0", req_ready, rsp_valid);
        end
        issue(1'b0, 1'b0, 10'h3C1, 8'h00, lat, we_low, sel_bad);
        checks++;
        if (rsp_data !== 8'h11 || rsp_err !== 1'b0) begin
            failures++;
            $display("FAIL midwr_ram: data=%h err=%b, expected 11 0", rsp_data, rsp_err);
        end
        handshake();
    endtask

    task automatic test_irq();
        bus_irq = 1'b1;
        @(posedge phi2); #1;
        checks++;
        if (irq_level !== 1'b0 || irq_rise !== 1'b0) begin
            failures++;
            $display("FAIL irq_edge1: level=%b rise=%b, expected 0 0", irq_level, irq_rise);
        end
        @(posedge phi2); #1;
        checks++;
        if (irq_level !== 1'b1 || irq_rise !== 1'b1) begin
            failures++;
            $display("FAIL irq_edge2: level=%b rise=%b, expected 1 1", irq_level, irq_rise);
        end
        @(posedge phi2); #1;
        checks++;
        if (irq_level !== 1'b1 || irq_rise !== 1'b0) begin
            failures++;
            $display("FAIL irq_edge3: level=%b rise=%b, expected 1 0", irq_level, irq_rise);
        end
        bus_irq = 1'b0;
        repeat (2) @(posedge phi2);
        #1;
        checks++;
        if (irq_level !== 1'b0 || irq_rise !== 1'b0) begin
            failures++;
            $display("FAIL irq_fall: level=%b rise=%b, expected 0 0", irq_level, irq_rise);
        end
    endtask

    initial begin
        rst = 1'b1; ram_clr = 1'b1; oe_en = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_rom = 1'b0; req_addr = '0; req_wdata = '0;
        rsp_ready = 1'b0; bus_irq = 1'b0;
        test_reset();
        test_write_read();
        test_rom_read();
        test_open_bus();
        test_back_to_back();
        test_reset_mid_write();
        test_irq();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
